// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the write-back path and
// its hazard logic.
package regfile_pkg;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping), as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int   cand;
    logic found;

    // The grant is a pure function of req and ptr, so ready never feeds back into valid.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IW-1:0]]    = 1'b1;
                gnt_idx              = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the register file's single write port: round-robin
// arbitration, one registered write stage and a pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*REG_AW-1:0] req_rd,
    input  logic [NREQ*XLEN-1:0]   req_data,
    input  logic                   claim_en,
    input  reg_addr_t              claim_rd,
    input  reg_addr_t              q_a1,
    input  reg_addr_t              q_a2,
    output logic                   q_busy1,
    output logic                   q_busy2,
    output logic                   we3,
    output reg_addr_t              a3,
    output logic [XLEN-1:0]        wd3
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic             hs;
    reg_addr_t        win_rd;
    logic [XLEN-1:0]  win_data;
    logic [NREGS-1:0] busy;

    rr_arbiter #(.N(NREQ), .IW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = reset ? '0 : gnt;
    assign hs        = |(req_valid & req_ready);
    assign win_rd    = req_rd[int'(gnt_idx)*REG_AW +: REG_AW];
    assign win_data  = req_data[int'(gnt_idx)*XLEN +: XLEN];

    // A handshake to x0 still consumes the grant and moves the pointer, but never writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            we3 <= 1'b0;
            a3  <= REG_ZERO;
            wd3 <= '0;
        end else begin
            we3 <= hs && (win_rd != REG_ZERO);
            if (hs) begin
                ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (win_rd != REG_ZERO) begin
                    a3  <= win_rd;
                    wd3 <= win_data;
                end
            end
        end
    end

    // Set comes after clear so a same-edge claim of the committing register wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (we3 && (a3 != REG_ZERO))
                busy[a3] <= 1'b0;
            if (claim_en && (claim_rd != REG_ZERO))
                busy[claim_rd] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    assign q_busy1 = busy[q_a1];
    assign q_busy2 = busy[q_a2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*DW-1:0]   req_data;
    logic                 claim_en;
    logic [AW-1:0]        claim_rd;
    logic [AW-1:0]        q_a1;
    logic [AW-1:0]        q_a2;
    logic                 q_busy1;
    logic                 q_busy2;
    logic                 we3;
    logic [AW-1:0]        a3;
    logic [DW-1:0]        wd3;

    int nChecks = 0;
    int nFails  = 0;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .claim_en  (claim_en),
        .claim_rd  (claim_rd),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3)
    );

    always #5 clk = ~clk;

    // Reference model: rr pointer, set of pending registers, and the write seen next cycle.
    int          m_ptr;
    bit          m_busy[32];
    bit          m_we;
    int          m_a3;
    logic [31:0] m_wd;
    bit          modelValid = 1'b0;
    int          m_g;
    int          m_rd;

    function automatic int grantOf(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (((v >> ((p + k) % NREQ)) & 1) != 0)
                return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_ptr = 0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_we = 1'b0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            m_g = grantOf(req_valid, m_ptr);
            if (m_we && m_a3 != 0) m_busy[m_a3] = 1'b0;
            if (claim_en && claim_rd != 0) m_busy[claim_rd] = 1'b1;
            if (m_g >= 0) begin
                m_rd = int'((req_rd >> (m_g * AW)) & 15'h1f);
                m_we = (m_rd != 0);
                if (m_we) begin
                    m_a3 = m_rd;
                    m_wd = 32'((req_data >> (m_g * DW)) & 96'hFFFF_FFFF);
                end
                m_ptr = (m_g + 1) % NREQ;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    logic [NREQ-1:0] expReady;
    int              cg;

    always @(negedge clk) begin
        if (modelValid) begin
            cg = grantOf(req_valid, m_ptr);
            expReady = (reset || cg < 0) ? '0 : NREQ'(1) << cg;
            checkOutput("req_ready", 64'(req_ready), 64'(expReady));
            checkOutput("we3", 64'(we3), 64'(m_we));
            if (m_we) begin
                checkOutput("a3", 64'(a3), 64'(m_a3));
                checkOutput("wd3", 64'(wd3), 64'(m_wd));
            end
            checkOutput("q_busy1", 64'(q_busy1), 64'(m_busy[q_a1]));
            checkOutput("q_busy2", 64'(q_busy2), 64'(m_busy[q_a2]));
        end
    end

    task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] v,
                                 input logic [NREQ*AW-1:0] rd, input logic [NREQ*DW-1:0] d,
                                 input logic cen, input logic [AW-1:0] crd,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        reset     = rst;
        req_valid = v;
        req_rd    = rd;
        req_data  = d;
        claim_en  = cen;
        claim_rd  = crd;
        q_a1      = a1;
        q_a2      = a2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #2;
    endtask

    localparam logic [NREQ*AW-1:0] RD123 = {5'd3, 5'd2, 5'd1};
    localparam logic [NREQ*DW-1:0] DABC  = {32'hC, 32'hB, 32'hA};

    initial begin
        applyStimulus(1'b1, 3'b111, RD123, DABC, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int c = 0; c < 2; c++) begin
            settle();
            checkOutput("reset_ready", 64'(req_ready), 64'd0);
            checkOutput("reset_we3", 64'(we3), 64'd0);
            checkOutput("reset_a3", 64'(a3), 64'd0);
            checkOutput("reset_wd3", 64'(wd3), 64'd0);
            advance();
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b0, 5'd0, 5'(i), 5'(i + 16));
            settle();
            checkOutput("reset_busy1", 64'(q_busy1), 64'd0);
            checkOutput("reset_busy2", 64'(q_busy2), 64'd0);
            advance();
        end

        applyStimulus(1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 5'd0, 5'd0, 5'd0);
        settle();
        checkOutput("single_ready", 64'(req_ready), 64'h1);
        advance();
        applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b0, 5'd0, 5'd0, 5'd0);
        settle();
        checkOutput("single_we3", 64'(we3), 64'd1);
        checkOutput("single_a3", 64'(a3), 64'd5);
        checkOutput("single_wd3", 64'(wd3), 64'hDEADBEEF);
        advance();

        applyStimulus(1'b1, 3'b000, RD123, DABC, 1'b0, 5'd0, 5'd0, 5'd0);
        advance();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, (k < 6) ? 3'b111 : 3'b000, RD123, DABC, 1'b0, 5'd0, 5'd0, 5'd0);
            settle();
            if (k < 6)
                checkOutput("rr_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
            if (k > 0) begin
                checkOutput("rr_we3", 64'(we3), 64'd1);
                checkOutput("rr_a3", 64'(a3), 64'((k - 1) % 3 + 1));
            end
            advance();
        end

        applyStimulus(1'b0, 3'b010, {5'd3, 5'd0, 5'd1}, {32'hC, 32'h1234, 32'hA}, 1'b0, 5'd0, 5'd0, 5'd0);
        settle();
        checkOutput("x0_ready", 64'(req_ready), 64'h2);
        advance();
        applyStimulus(1'b0, 3'b111, RD123, DABC, 1'b0, 5'd0, 5'd0, 5'd0);
        settle();
        checkOutput("x0_we3", 64'(we3), 64'd0);
        checkOutput("x0_ptr_ready", 64'(req_ready), 64'h4);
        advance();
        applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b0, 5'd0, 5'd0, 5'd0);
        advance();

        applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b1, 5'd7, 5'd7, 5'd0);
        settle();
        checkOutput("claim_before", 64'(q_busy1), 64'd0);
        advance();
        applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b0, 5'd7, 5'd7, 5'd0);
        settle();
        checkOutput("claim_busy", 64'(q_busy1), 64'd1);
        advance();
        applyStimulus(1'b0, 3'b001, {5'd3, 5'd2, 5'd7}, DABC, 1'b0, 5'd0, 5'd7, 5'd0);
        settle();
        checkOutput("wb7_ready", 64'(req_ready), 64'h1);
        advance();
        applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b0, 5'd0, 5'd7, 5'd0);
        settle();
        checkOutput("wb7_we3", 64'(we3), 64'd1);
        checkOutput("wb7_a3", 64'(a3), 64'd7);
        checkOutput("wb7_busy_during", 64'(q_busy1), 64'd1);
        advance();
        settle();
        checkOutput("wb7_busy_after", 64'(q_busy1), 64'd0);
        advance();
        applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b1, 5'd7, 5'd7, 5'd0);
        advance();
        applyStimulus(1'b0, 3'b001, {5'd3, 5'd2, 5'd7}, DABC, 1'b0, 5'd0, 5'd7, 5'd0);
        advance();
        applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b1, 5'd7, 5'd7, 5'd0);
        settle();
        checkOutput("race_we3", 64'(we3), 64'd1);
        advance();
        applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b0, 5'd0, 5'd7, 5'd0);
        settle();
        checkOutput("race_claim_wins", 64'(q_busy1), 64'd1);
        advance();

        applyStimulus(1'b0, 3'b000, RD123, DABC, 1'b1, 5'd9, 5'd0, 5'd9);
        advance();
        applyStimulus(1'b0, 3'b100, {5'd9, 5'd2, 5'd1}, {32'h99, 32'hB, 32'hA}, 1'b0, 5'd0, 5'd0, 5'd9);
        settle();
        checkOutput("inflight_ready", 64'(req_ready), 64'h4);
        advance();
        applyStimulus(1'b1, 3'b000, RD123, DABC, 1'b0, 5'd0, 5'd0, 5'd9);
        advance();
        applyStimulus(1'b0, 3'b111, RD123, DABC, 1'b0, 5'd0, 5'd0, 5'd9);
        settle();
        checkOutput("drop_we3", 64'(we3), 64'd0);
        checkOutput("drop_busy9", 64'(q_busy2), 64'd0);
        checkOutput("drop_ptr_ready", 64'(req_ready), 64'h1);
        advance();

        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          NREQ'($urandom),
                          NREQ*AW'({$urandom, $urandom}),
                          {$urandom, $urandom, $urandom},
                          ($urandom_range(0, 2) == 0),
                          5'($urandom), 5'($urandom), 5'($urandom));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
